// File: rtl/gray_pkg.sv
// Shared definitions for the RGB-to-grayscale stage.
// Contents: FSM state encoding, default luma weights, sum width and
// rounding constant used by gray_mac and rgb_to_gray.
package gray_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_EMIT    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // BT.601-style integer weights; they sum to 256 so >>8 normalises.
  localparam int DEF_WR = 77;
  localparam int DEF_WG = 150;
  localparam int DEF_WB = 29;

  // Three 16-bit products plus rounding fit in 18 bits.
  localparam int SUM_W = 18;
  localparam logic [SUM_W-1:0] ROUND_C = 18'd128;

endpackage

// File: rtl/gray_mac.sv
// Combinational weighted sum of one RGB pixel with rounding and saturation.
// Ports:
//   r, g, b : in  8-bit colour components
//   gray    : out 8-bit luma, (WR*r + WG*g + WB*b + 128) >> 8, clamped to 255
module gray_mac
  import gray_pkg::*;
#(
  parameter int WR = DEF_WR,
  parameter int WG = DEF_WG,
  parameter int WB = DEF_WB
) (
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] gray
);

  localparam logic [7:0] WR_C = 8'(WR);
  localparam logic [7:0] WG_C = 8'(WG);
  localparam logic [7:0] WB_C = 8'(WB);

  logic [15:0]      prod_r_s;
  logic [15:0]      prod_g_s;
  logic [15:0]      prod_b_s;
  logic [SUM_W-1:0] sum_s;

  // Zero-extend to 16 bits so each product keeps its full width.
  assign prod_r_s = {8'd0, WR_C} * {8'd0, r};
  assign prod_g_s = {8'd0, WG_C} * {8'd0, g};
  assign prod_b_s = {8'd0, WB_C} * {8'd0, b};
  assign sum_s    = {2'b00, prod_r_s} + {2'b00, prod_g_s} + {2'b00, prod_b_s} + ROUND_C;

  // Saturate when weights that do not sum to 256 push the result past 8 bits.
  always_comb begin
    gray = 8'h00;
    if (sum_s[17:16] != 2'b00) begin
      gray = 8'hFF;
    end else begin
      gray = sum_s[15:8];
    end
  end

endmodule

// File: rtl/rgb_to_gray.sv
// Grayscaling stage: collects byte-serial R,G,B triplets from the camera,
// computes one luma byte per pixel and hands it to memory with a
// valid/ready handshake; pulses GS_done after N*M pixels are consumed.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   GS_enable   : in  high = process frame, low = abort to idle
//   pix_valid   : in  camera byte present on pix_data
//   pix_data    : in  camera byte, order R,G,B
//   pix_ready   : out stage accepts pix_data this cycle
//   out_ready   : in  downstream consumes data_out this cycle
//   data_out    : out gray byte (holds last value when GS_valid is low)
//   GS_valid    : out data_out holds a valid gray byte
//   GS_done     : out one-cycle pulse after the last pixel of a frame is consumed
module rgb_to_gray
  import gray_pkg::*;
#(
  parameter int N  = 2,
  parameter int M  = 2,
  parameter int WR = DEF_WR,
  parameter int WG = DEF_WG,
  parameter int WB = DEF_WB
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       GS_enable,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  output logic       pix_ready,
  input  logic       out_ready,
  output logic [7:0] data_out,
  output logic       GS_valid,
  output logic       GS_done
);

  localparam int PIX_W = $clog2(N * M) + 1;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(N * M - 1);
  localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);

  state_t           state_r;
  logic [1:0]       byte_cnt_r;
  logic [PIX_W-1:0] pix_cnt_r;
  logic [7:0]       red_r;
  logic [7:0]       green_r;
  logic [7:0]       blue_r;
  logic [7:0]       gray_s;

  gray_mac #(
    .WR (WR),
    .WG (WG),
    .WB (WB)
  ) u_mac (
    .r    (red_r),
    .g    (green_r),
    .b    (blue_r),
    .gray (gray_s)
  );

  // Frame FSM with counters, capture registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      byte_cnt_r <= 2'd0;
      pix_cnt_r  <= '0;
      red_r      <= 8'h00;
      green_r    <= 8'h00;
      blue_r     <= 8'h00;
      pix_ready  <= 1'b0;
      data_out   <= 8'h00;
      GS_valid   <= 1'b0;
      GS_done    <= 1'b0;
    end else if ((state_r != ST_IDLE) && !GS_enable) begin
      // Abort takes priority over any transfer or consume in the same cycle;
      // data_out keeps its last value.
      state_r    <= ST_IDLE;
      byte_cnt_r <= 2'd0;
      pix_cnt_r  <= '0;
      pix_ready  <= 1'b0;
      GS_valid   <= 1'b0;
      GS_done    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          GS_done <= 1'b0;
          if (GS_enable) begin
            state_r    <= ST_COLLECT;
            byte_cnt_r <= 2'd0;
            pix_cnt_r  <= '0;
            pix_ready  <= 1'b1;
          end else begin
            pix_ready <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (pix_valid && pix_ready) begin
            case (byte_cnt_r)
              2'd0:    red_r   <= pix_data;
              2'd1:    green_r <= pix_data;
              default: blue_r  <= pix_data;
            endcase
            if (byte_cnt_r == 2'd2) begin
              byte_cnt_r <= 2'd0;
              pix_ready  <= 1'b0;
              state_r    <= ST_COMPUTE;
            end else begin
              byte_cnt_r <= byte_cnt_r + 2'd1;
            end
          end else begin
            byte_cnt_r <= byte_cnt_r;
          end
        end
        ST_COMPUTE: begin
          data_out <= gray_s;
          GS_valid <= 1'b1;
          state_r  <= ST_EMIT;
        end
        ST_EMIT: begin
          if (out_ready) begin
            GS_valid  <= 1'b0;
            pix_cnt_r <= pix_cnt_r + PIX_ONE;
            if (pix_cnt_r == LAST_PIX) begin
              GS_done <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              pix_ready <= 1'b1;
              state_r   <= ST_COLLECT;
            end
          end else begin
            GS_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          GS_done    <= 1'b0;
          byte_cnt_r <= 2'd0;
          pix_cnt_r  <= '0;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          byte_cnt_r <= 2'd0;
          pix_cnt_r  <= '0;
          pix_ready  <= 1'b0;
          GS_valid   <= 1'b0;
          GS_done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_to_gray.sv
// Self-checking bench for rgb_to_gray (N=M=2): directed pixels from the
// feature list plus random frames, all checked against a luma model.
module tb_rgb_to_gray;

  localparam int N_PIX = 4;

  logic       clk;
  logic       rst_n;
  logic       GS_enable;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_ready;
  logic       out_ready;
  logic [7:0] data_out;
  logic       GS_valid;
  logic       GS_done;

  int vectors;
  int miscompares;
  int done_seen;

  rgb_to_gray #(.N(2), .M(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .GS_enable (GS_enable),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .out_ready (out_ready),
    .data_out  (data_out),
    .GS_valid  (GS_valid),
    .GS_done   (GS_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (GS_done === 1'b1) done_seen++;
  end

  // Luma model: rounded weighted average, clamped to one byte.
  function automatic logic [7:0] ref_gray(input int r, input int g, input int b);
    int s;
    s = (77 * r + 150 * g + 29 * b + 128) / 256;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  task automatic send_byte(input logic [7:0] d, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      pix_valid = 1'b0;
      pix_data  = 8'($urandom);
      @(negedge clk);
    end
    pix_valid = 1'b1;
    pix_data  = d;
    n = 0;
    while (pix_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL send_byte: pix_ready never rose, got %b required 1", pix_ready);
    end
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic run_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input int gap, input int hold, input logic last);
    logic [7:0] exp;
    int n;
    exp = ref_gray(int'(r), int'(g), int'(b));
    send_byte(r, gap);
    send_byte(g, gap);
    send_byte(b, gap);
    n = 0;
    while (GS_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n != 1 || data_out !== exp) begin
      miscompares++;
      $display("FAIL pixel(%0d,%0d,%0d): data_out %0d after %0d cycles, required %0d after 1",
               r, g, b, data_out, n, exp);
    end
    for (int i = 0; i < hold; i++) begin
      pix_valid = 1'b1;
      pix_data  = 8'($urandom);
      @(negedge clk);
      vectors++;
      if (GS_valid !== 1'b1 || data_out !== exp || pix_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold: valid=%b data=%0d ready=%b, required valid=1 data=%0d ready=0",
                 GS_valid, data_out, pix_ready, exp);
      end
    end
    pix_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (GS_valid !== 1'b0 || GS_done !== last) begin
      miscompares++;
      $display("FAIL consume: GS_valid=%b GS_done=%b, required 0 and %b", GS_valid, GS_done, last);
    end
    if (last) begin
      @(negedge clk);
      vectors++;
      if (GS_done !== 1'b0) begin
        miscompares++;
        $display("FAIL done_width: GS_done=%b, required 0", GS_done);
      end
    end
  endtask

  task automatic test_reset;
    vectors++;
    if (pix_ready !== 1'b0 || GS_valid !== 1'b0 || GS_done !== 1'b0 || data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset: ready=%b valid=%b done=%b data=%0d, required all 0",
               pix_ready, GS_valid, GS_done, data_out);
    end
  endtask

  task automatic test_single_pixel;
    GS_enable = 1'b1;
    out_ready = 1'b1;
    send_byte(8'd255, 0);
    send_byte(8'd0, 0);
    send_byte(8'd0, 0);
    vectors++;
    if (GS_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early: GS_valid=%b one cycle after B, required 0", GS_valid);
    end
    @(negedge clk);
    vectors++;
    if (GS_valid !== 1'b1 || data_out !== 8'd77) begin
      miscompares++;
      $display("FAIL single_value: valid=%b data=%0d, required 1 and 77", GS_valid, data_out);
    end
    @(negedge clk);
    vectors++;
    if (GS_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_width: GS_valid=%b, required 0", GS_valid);
    end
    out_ready = 1'b0;
    GS_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_frame;
    GS_enable = 1'b1;
    run_pixel(8'd0, 8'd255, 8'd0, 0, 0, 1'b0);
    run_pixel(8'd0, 8'd0, 8'd255, 0, 5, 1'b0);
    run_pixel(8'd255, 8'd255, 8'd255, 0, 0, 1'b0);
    run_pixel(8'd100, 8'd150, 8'd200, 3, 0, 1'b1);
  endtask

  task automatic test_abort;
    int done_before;
    int bad;
    GS_enable = 1'b1;
    run_pixel(8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 1'b0);
    send_byte(8'd10, 0);
    send_byte(8'd20, 0);
    // Enable falls in the same cycle the B byte is offered.
    done_before = done_seen;
    GS_enable = 1'b0;
    pix_valid = 1'b1;
    pix_data  = 8'd30;
    @(negedge clk);
    pix_valid = 1'b0;
    vectors++;
    if (pix_ready !== 1'b0 || GS_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_drop: ready=%b valid=%b, required 0 0", pix_ready, GS_valid);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (GS_valid !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0 || done_seen != done_before) begin
      miscompares++;
      $display("FAIL abort_quiet: %0d valid cycles, %0d done pulses, required 0 0",
               bad, done_seen - done_before);
    end
    GS_enable = 1'b1;
    for (int k = 0; k < N_PIX; k++) begin
      run_pixel(8'($urandom), 8'($urandom), 8'($urandom), 0, 0, k == N_PIX - 1);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    GS_enable = 1'b1;
    send_byte(8'd255, 0);
    send_byte(8'd255, 0);
    send_byte(8'd255, 0);
    n = 0;
    while (GS_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (data_out !== 8'd255) begin
      miscompares++;
      $display("FAIL pre_reset: data_out=%0d, required 255", data_out);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (GS_valid !== 1'b0 || data_out !== 8'h00 || pix_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b data=%0d ready=%b, required 0 0 0",
               GS_valid, data_out, pix_ready);
    end
    GS_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    GS_enable = 1'b1;
    for (int k = 0; k < N_PIX; k++) begin
      run_pixel(8'($urandom), 8'($urandom), 8'($urandom), 1, 1, k == N_PIX - 1);
    end
  endtask

  task automatic test_random_frames;
    GS_enable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N_PIX; k++) begin
        run_pixel(8'($urandom), 8'($urandom), 8'($urandom),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), k == N_PIX - 1);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    done_seen   = 0;
    rst_n       = 1'b0;
    GS_enable   = 1'b0;
    pix_valid   = 1'b0;
    pix_data    = 8'h00;
    out_ready   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_pixel();
    test_frame();
    test_abort();
    test_reset_mid();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
